hypercorex_inst_fetch: RTL
==========================

# hypercorex_inst_fetch

Instruction memory and sequencer that sits directly upstream of the Hypercorex instruction decoder. Holds a small program of 32-bit instruction words, loaded through a simple write port. On start it streams the program to the decoder over a valid/ready handshake, repeating the whole program a programmable number of times. It reports busy and done status to the control/CSR layer.

## Interface
- InstWidth, 32, instruction word width; must match the decoder's format.
- NumInst, 64, instruction memory depth in words; must be a power of 2 and at least 2.
- LoopWidth, 16, width of the program repeat counter.
- PcWidth, $clog2(NumInst), program counter and write address width (derived).
- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- inst_wr_en_i  in  1  write strobe into instruction memory.
- inst_wr_addr_i  in  PcWidth  write address.
- inst_wr_data_i  in  InstWidth  write data.
- start_i  in  1  one-cycle pulse that begins program execution.
- stop_i  in  1  abort execution.
- inst_len_i  in  PcWidth+1  number of program words; sampled on start.
- loop_count_i  in  LoopWidth  number of program repetitions; sampled on start.
- inst_valid_o  out  1  inst_code_o/inst_pc_o carry a valid instruction.
- inst_ready_i  in  1  decoder accepts the current instruction.
- inst_code_o  out  InstWidth  current instruction word; 0 when not valid.
- inst_pc_o  out  PcWidth  address of the current instruction.
- busy_o  out  1  sequencer in RUN.
- done_o  out  1  one-cycle pulse on normal completion.

## Operation
- Memory: NumInst x InstWidth flop array. All words reset to 0. Read is combinational from the pc register.
- Writes:
  - A write takes effect at the clock edge when inst_wr_en_i=1 and state is IDLE.
  - Writes while in RUN are dropped silently.
- FSM has two states, IDLE and RUN.
- IDLE → RUN when start_i=1 and inst_len_i != 0. On this edge:
  - pc←0, iter←0.
  - len_q←min(inst_len_i, NumInst).
  - loops_q←max(loop_count_i, 1); a loop count of 0 runs once.
- start_i with inst_len_i=0 is ignored and the block stays in IDLE.
- In RUN:
  - inst_valid_o=1, inst_code_o=mem[pc], inst_pc_o=pc.
  - Outputs hold stable while inst_ready_i=0.
- On a handshake (inst_valid_o & inst_ready_i):
  - pc != len_q-1: pc←pc+1.
  - pc == len_q-1 and iter != loops_q-1: pc←0 (wrap), iter←iter+1.
  - pc == len_q-1 and iter == loops_q-1: go to IDLE, pc←0, done_o=1 on the next cycle.
- stop_i=1 in RUN forces IDLE, pc←0, with no done pulse. stop_i has priority over a simultaneous handshake, so that instruction counts as not consumed.
- start_i while in RUN is ignored. stop_i while in IDLE has no effect.
- Changing inst_len_i or loop_count_i during RUN has no effect; both are captured only at start.
- busy_o=1 exactly when state is RUN.

## Timing
- Reset values: inst_valid_o=0, inst_code_o=0, inst_pc_o=0, busy_o=0, done_o=0. State is IDLE, pc=0, iter=0, memory all 0.
- Reset is honoured mid-RUN: all of the above take effect immediately (asynchronously) and the program is lost.
- Start latency: start_i sampled at edge t gives inst_valid_o=1 and busy_o=1 in the cycle after t, with pc=0.
- Throughput: one instruction per cycle while inst_ready_i=1.
- Final handshake at edge t gives busy_o=0, inst_valid_o=0 and done_o=1 in the cycle after t. done_o is 0 in the following cycle.
- A start pulse in the same cycle that done_o is high is accepted, because state is already IDLE.
- A write at edge t is readable at the cycle after t.
- Total handshakes per run = len_q × loops_q.

## Test plan
- Reset then idle: all outputs 0, and start_i with inst_len_i=0 never raises busy_o.
- Single pass:
  - Stimulus: write 0xA0,0xA1,0xA2 to addresses 0..2; start with len=3, loop=1; inst_ready_i=1.
  - Required: codes A0,A1,A2 on three consecutive cycles, pc 0,1,2, then done_o for one cycle.
- Looping with backpressure:
  - Stimulus: len=2, loop=3; inst_ready_i toggling 1,0.
  - Required: exactly 6 handshakes, pc sequence 0,1,0,1,0,1, outputs stable during ready=0, one done pulse.
- Edge values:
  - Stimulus: loop_count=0, and separately inst_len_i=NumInst+5.
  - Required: loop=0 runs once; the oversize length runs NumInst words.
- Writes during RUN:
  - Stimulus: write 0xFF to address 1 while running.
  - Required: the write is ignored and a rerun still shows the original word.
- Abort and reset mid-run:
  - Stimulus: stop_i asserted concurrently with a handshake at pc=1.
  - Required: returns to IDLE with no done pulse. After asserting rst_i mid-run, memory reads back 0.

Source files
------------

// File: rtl/hypercorex_inst_fetch.sv
// hypercorex_inst_fetch
// Instruction memory and sequencer placed directly upstream of the Hypercorex
// instruction decoder. A program is loaded through the write port while idle.
// A start pulse then streams it to the decoder over a valid/ready handshake,
// and the whole program is repeated loop_count_i times.
//
// Ports
//   clk_i, rst_i                  clock, async active-high reset
//   inst_wr_en_i/addr_i/data_i    program load port (honoured in IDLE only)
//   start_i, stop_i               begin / abort execution
//   inst_len_i, loop_count_i      program length and repeat count, captured on start
//   inst_valid_o, inst_ready_i    handshake to the decoder
//   inst_code_o, inst_pc_o        current instruction word and its address
//   busy_o, done_o                running flag, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start; program memory writable
// RUN   | presenting mem[pc] to the decoder, advancing on each handshake
module hypercorex_inst_fetch #(
   parameter int InstWidth = 32,
   parameter int NumInst   = 64,
   parameter int LoopWidth = 16,
   parameter int PcWidth   = $clog2(NumInst)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inst_wr_en_i,
   input  logic [PcWidth-1:0]   inst_wr_addr_i,
   input  logic [InstWidth-1:0] inst_wr_data_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [PcWidth:0]     inst_len_i,
   input  logic [LoopWidth-1:0] loop_count_i,
   output logic                 inst_valid_o,
   input  logic                 inst_ready_i,
   output logic [InstWidth-1:0] inst_code_o,
   output logic [PcWidth-1:0]   inst_pc_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [PcWidth:0]     MaxLen  = (PcWidth+1)'(NumInst);
   localparam logic [PcWidth:0]     LenOne  = (PcWidth+1)'(1);
   localparam logic [LoopWidth-1:0] LoopOne = LoopWidth'(1);
   localparam logic [PcWidth-1:0]   PcOne   = PcWidth'(1);

   state_t                 state_q, state_d;
   logic [InstWidth-1:0]   mem_q [NumInst];
   logic [PcWidth-1:0]     pc_q, pc_d;
   logic [LoopWidth-1:0]   iter_q, iter_d;
   logic [LoopWidth-1:0]   loops_q, loops_d;
   logic [PcWidth:0]       len_q, len_d;
   logic                   done_q, done_d;
   logic                   handshake;
   logic                   pc_last;
   logic                   iter_last;

   assign handshake = (state_q == RUN) && inst_ready_i;
   // len_q is never 0 in RUN, so len_q-1 cannot underflow where it matters.
   assign pc_last   = ({1'b0, pc_q} == (len_q - LenOne));
   assign iter_last = (iter_q == (loops_q - LoopOne));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumInst; i++) begin
            mem_q[i] <= '0;
         end
      end else if (inst_wr_en_i && (state_q == IDLE)) begin
         mem_q[inst_wr_addr_i] <= inst_wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= '0;
         iter_q  <= '0;
         loops_q <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         iter_q  <= iter_d;
         loops_q <= loops_d;
         len_q   <= len_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      iter_d  = iter_q;
      loops_d = loops_q;
      len_d   = len_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && (inst_len_i != '0)) begin
               state_d = RUN;
               pc_d    = '0;
               iter_d  = '0;
               len_d   = (inst_len_i > MaxLen) ? MaxLen : inst_len_i;
               // A repeat count of 0 still runs the program once.
               loops_d = (loop_count_i == '0) ? LoopOne : loop_count_i;
            end
         end
         RUN: begin
            // stop wins over a coincident handshake; that word is not consumed.
            if (stop_i) begin
               state_d = IDLE;
               pc_d    = '0;
               iter_d  = '0;
            end else if (handshake) begin
               if (!pc_last) begin
                  pc_d = pc_q + PcOne;
               end else if (!iter_last) begin
                  pc_d   = '0;
                  iter_d = iter_q + LoopOne;
               end else begin
                  state_d = IDLE;
                  pc_d    = '0;
                  iter_d  = '0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
            iter_d  = '0;
         end
      endcase
   end

   always_comb begin
      inst_valid_o = (state_q == RUN);
      busy_o       = (state_q == RUN);
      inst_code_o  = (state_q == RUN) ? mem_q[pc_q] : '0;
      inst_pc_o    = pc_q;
      done_o       = done_q;
   end

endmodule
